// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared floating-point types, constants and classifiers
package fp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] frac;
    } fp_t;

    typedef enum logic {
        RM_RNE = 1'b0,
        RM_RTZ = 1'b1
    } rmode_e;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic inexact;
    } fp_flags_t;

    localparam fp_t QNAN = '{sign: 1'b0, exp: '1, frac: {1'b1, {(MAN_W-1){1'b0}}}};

    function automatic logic is_nan(input fp_t x);
        return (&x.exp) && (|x.frac);
    endfunction

    function automatic logic is_inf(input fp_t x);
        return (&x.exp) && !(|x.frac);
    endfunction

    // Subnormals count as zero because the adder flushes them on input.
    function automatic logic is_zero(input fp_t x);
        return (x.exp == '0);
    endfunction

endpackage

// File: rtl/fp_add_pipe_if.sv
// rtl/fp_add_pipe_if.sv - operand/result handshake bundle for the pipelined adder
interface fp_add_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         rmode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res;
    logic [2:0]   flags;

    // Issuer side: drives operands and accepts results.
    modport master (
        output in_valid, a, b, sub, rmode, out_ready,
        input  in_ready, out_valid, res, flags
    );

    // Adder side.
    modport slave (
        input  in_valid, a, b, sub, rmode, out_ready,
        output in_ready, out_valid, res, flags
    );
endinterface

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - combinational leading-zero counter, all-zero input yields WIDTH
module fp_lzc #(
    parameter int WIDTH = 27,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] in,
    output logic [CW-1:0]    count
);

    // Scan upward so the highest set bit wins the priority.
    always_comb begin
        count = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (in[i]) begin
                count = CW'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_add_pipe.sv
// rtl/fp_add_pipe.sv - 3-stage IEEE-754 adder/subtractor with valid/ready backpressure
module fp_add_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic          clk,
    input  logic          rst,
    fp_add_pipe_if.slave  io
);
    import fp_pkg::*;

    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int SW  = MAN_W + 4;            // hidden + frac + guard/round/sticky
    localparam int LZW = $clog2(SW + 1);

    localparam logic [W-1:0] QNAN_W = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic              valid;
        logic              sign;
        logic              eff_sub;
        logic [EXP_W-1:0]  exp;
        logic [SW-1:0]     sig_l;
        logic [SW-1:0]     sig_s;
        rmode_e            rm;
        logic              spec;
        logic [W-1:0]      spec_res;
        fp_flags_t         spec_flags;
    } s1_t;

    typedef struct packed {
        logic              valid;
        logic              sign;
        logic [EXP_W:0]    exp;
        logic [SW-1:0]     norm;
        rmode_e            rm;
        logic              spec;
        logic [W-1:0]      spec_res;
        fp_flags_t         spec_flags;
    } s2_t;

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;

    logic         out_valid_q;
    logic [W-1:0] res_q;
    fp_flags_t    flags_q;

    logic stall;
    assign stall       = out_valid_q & ~io.out_ready;
    assign io.in_ready = ~stall;
    assign io.out_valid = out_valid_q;
    assign io.res       = res_q;
    assign io.flags     = flags_q;

    // ---------------- S1: unpack, classify, order and align ----------------
    logic             sa, sb, sl, ss;
    logic [EXP_W-1:0] ea, eb, el, es, d;
    logic [MAN_W-1:0] fa, fb, fl, fs;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_big, lost;
    logic [SW-1:0]    sig_s, sig_sh;

    // Build the aligned operand pair and any bypass result for the incoming op.
    always_comb begin
        sa     = io.a[W-1];
        ea     = io.a[W-2:MAN_W];
        fa     = (ea == '0) ? '0 : io.a[MAN_W-1:0];
        sb     = io.b[W-1] ^ io.sub;
        eb     = io.b[W-2:MAN_W];
        fb     = (eb == '0) ? '0 : io.b[MAN_W-1:0];
        a_nan  = (&ea) && (|fa);
        b_nan  = (&eb) && (|fb);
        a_inf  = (&ea) && !(|fa);
        b_inf  = (&eb) && !(|fb);
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_big  = ({ea, fa} >= {eb, fb});
        sl     = a_big ? sa : sb;
        el     = a_big ? ea : eb;
        fl     = a_big ? fa : fb;
        ss     = a_big ? sb : sa;
        es     = a_big ? eb : ea;
        fs     = a_big ? fb : fa;
        d      = el - es;
        sig_s  = {1'b1, fs, 3'b000};
        lost   = 1'b0;
        sig_sh = '0;
        if (int'(d) >= SW - 1) begin
            sig_sh = {{(SW-1){1'b0}}, 1'b1};
        end else begin
            sig_sh    = sig_s >> d;
            lost      = |(sig_s & ~({SW{1'b1}} << d));
            sig_sh[0] = sig_sh[0] | lost;
        end

        s1_d         = '0;
        s1_d.valid   = io.in_valid;
        s1_d.sign    = sl;
        s1_d.eff_sub = sl ^ ss;
        s1_d.exp     = el;
        s1_d.sig_l   = {1'b1, fl, 3'b000};
        s1_d.sig_s   = sig_sh;
        s1_d.rm      = rmode_e'(io.rmode);

        if (a_nan || b_nan) begin
            s1_d.spec     = 1'b1;
            s1_d.spec_res = QNAN_W;
        end else if (a_inf && b_inf) begin
            s1_d.spec = 1'b1;
            if (sa != sb) begin
                s1_d.spec_res           = QNAN_W;
                s1_d.spec_flags.invalid = 1'b1;
            end else begin
                s1_d.spec_res = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end
        end else if (a_inf) begin
            s1_d.spec     = 1'b1;
            s1_d.spec_res = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            s1_d.spec     = 1'b1;
            s1_d.spec_res = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero && b_zero) begin
            s1_d.spec     = 1'b1;
            s1_d.spec_res = {sa & sb, {(W-1){1'b0}}};
        end else if (b_zero) begin
            s1_d.spec     = 1'b1;
            s1_d.spec_res = {sa, ea, fa};
        end else if (a_zero) begin
            s1_d.spec     = 1'b1;
            s1_d.spec_res = {sb, eb, fb};
        end
    end

    // S1 register advances whenever the output is not blocked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
        end else if (!stall) begin
            s1_q <= s1_d;
        end
    end

    // ---------------- S2: add/subtract and normalise ----------------
    logic [SW:0]          sum;
    logic [LZW-1:0]       lz;
    logic signed [EXP_W+1:0] e_norm;

    fp_lzc #(.WIDTH(SW), .CW(LZW)) u_lzc (
        .in    (sum[SW-1:0]),
        .count (lz)
    );

    // Magnitude operation; the large operand is never smaller than the small one.
    always_comb begin
        sum    = s1_q.eff_sub ? ({1'b0, s1_q.sig_l} - {1'b0, s1_q.sig_s})
                              : ({1'b0, s1_q.sig_l} + {1'b0, s1_q.sig_s});
        e_norm = $signed({2'b00, s1_q.exp}) - $signed({{(EXP_W+2-LZW){1'b0}}, lz});

        s2_d            = '0;
        s2_d.valid      = s1_q.valid;
        s2_d.sign       = s1_q.sign;
        s2_d.rm         = s1_q.rm;
        s2_d.spec       = s1_q.spec;
        s2_d.spec_res   = s1_q.spec_res;
        s2_d.spec_flags = s1_q.spec_flags;

        if (!s1_q.spec) begin
            if (sum[SW]) begin
                s2_d.norm    = sum[SW:1];
                s2_d.norm[0] = sum[1] | sum[0];
                s2_d.exp     = {1'b0, s1_q.exp} + 1'b1;
            end else if (sum == '0) begin
                s2_d.spec     = 1'b1;
                s2_d.spec_res = '0;
            end else if (e_norm <= 0) begin
                s2_d.spec               = 1'b1;
                s2_d.spec_res           = {s1_q.sign, {(W-1){1'b0}}};
                s2_d.spec_flags.inexact = 1'b1;
            end else begin
                s2_d.norm = sum[SW-1:0] << lz;
                s2_d.exp  = e_norm[EXP_W:0];
            end
        end
    end

    // S2 register advances whenever the output is not blocked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_q <= '0;
        end else if (!stall) begin
            s2_q <= s2_d;
        end
    end

    // ---------------- S3: round and pack ----------------
    logic             g_bit, r_bit, st_bit, lsb, inc;
    logic [MAN_W+1:0] rounded;
    logic [EXP_W:0]   exp_r;
    logic [MAN_W-1:0] frac_r;
    logic [W-1:0]     res_d;
    fp_flags_t        flags_d;

    // Apply the rounding mode, renormalise on carry and saturate on overflow.
    always_comb begin
        lsb     = s2_q.norm[3];
        g_bit   = s2_q.norm[2];
        r_bit   = s2_q.norm[1];
        st_bit  = s2_q.norm[0];
        inc     = (s2_q.rm == RM_RNE) && g_bit && (r_bit || st_bit || lsb);
        rounded = {1'b0, s2_q.norm[SW-1:3]} + {{(MAN_W+1){1'b0}}, inc};
        exp_r   = s2_q.exp + {{EXP_W{1'b0}}, rounded[MAN_W+1]};
        frac_r  = rounded[MAN_W+1] ? rounded[MAN_W:1] : rounded[MAN_W-1:0];
        flags_d = '0;
        flags_d.inexact = g_bit | r_bit | st_bit;
        res_d   = {s2_q.sign, exp_r[EXP_W-1:0], frac_r};

        if (s2_q.spec) begin
            res_d   = s2_q.spec_res;
            flags_d = s2_q.spec_flags;
        end else if (exp_r >= {1'b0, {EXP_W{1'b1}}}) begin
            flags_d.overflow = 1'b1;
            flags_d.inexact  = 1'b1;
            if (s2_q.rm == RM_RNE) begin
                res_d = {s2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else begin
                res_d = {s2_q.sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
            end
        end
    end

    // Output register holds result and flags steady while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
            flags_q     <= '0;
        end else if (!stall) begin
            out_valid_q <= s2_q.valid;
            if (s2_q.valid) begin
                res_q   <= res_d;
                flags_q <= flags_d;
            end
        end
    end

endmodule

// File: tb/tb_fp_add_pipe.sv
// tb/tb_fp_add_pipe.sv - scoreboard bench for the pipelined floating-point adder
module tb_fp_add_pipe;

    logic clk;
    logic rst;

    fp_add_pipe_if #(.EXP_W(8), .MAN_W(23)) io ();

    fp_add_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [34:0] exp_q[$];
    logic [31:0] held_res;
    logic        held_v = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Drive one op; expected result is queued at the moment it is accepted.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s, input logic rm,
                        input logic [31:0] er, input logic [2:0] ef);
        int n = 0;
        @(negedge clk);
        io.in_valid = 1'b1;
        io.a = a;
        io.b = b;
        io.sub = s;
        io.rmode = rm;
        while (!io.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!io.in_ready) begin
            check("send_timeout", 32'(io.in_ready), 32'd1);
            io.in_valid = 1'b0;
        end else begin
            exp_q.push_back({er, ef});
            @(posedge clk);
            #1 io.in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: compare accepted results in order, and check the stall contract.
    initial begin
        logic [34:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_v = 1'b0;
            end else begin
                if (io.out_valid && held_v) check("stall_res_stable", io.res, held_res);
                if (io.out_valid && io.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", io.res, 32'hxxxxxxxx);
                    end else begin
                        e = exp_q.pop_front();
                        check("res", io.res, e[34:3]);
                        check("flags", 32'(io.flags), 32'(e[2:0]));
                    end
                    held_v = 1'b0;
                end else if (io.out_valid) begin
                    check("in_ready_low_stalled", 32'(io.in_ready), 32'd0);
                    held_res = io.res;
                    held_v   = 1'b1;
                end else begin
                    held_v = 1'b0;
                end
            end
        end
    end

    task automatic latency_test(input string name);
        int n = 1;
        send(32'h3F800000, 32'h40000000, 1'b0, 1'b0, 32'h40400000, 3'b000);
        #1;
        while (!io.out_valid && n < 10) begin
            @(posedge clk);
            n++;
            #1;
        end
        check(name, 32'(n), 32'd3);
        drain();
    endtask

    initial begin
        rst = 1'b1;
        io.in_valid = 1'b0;
        io.a = '0;
        io.b = '0;
        io.sub = 1'b0;
        io.rmode = 1'b0;
        io.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(io.out_valid), 32'd0);
        check("rst_res", io.res, 32'd0);
        check("rst_flags", 32'(io.flags), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("rst_in_ready", 32'(io.in_ready), 32'd1);

        latency_test("latency");

        // Directed vectors: a, b, sub, rmode, expected result, {invalid,overflow,inexact}
        send(32'h3F800000, 32'h3F800000, 1'b1, 1'b0, 32'h00000000, 3'b000);
        send(32'h40400000, 32'h3F800000, 1'b1, 1'b0, 32'h40000000, 3'b000);
        send(32'h3F800000, 32'h33800000, 1'b0, 1'b0, 32'h3F800000, 3'b001);
        send(32'h3F800000, 32'h33C00000, 1'b0, 1'b0, 32'h3F800001, 3'b001);
        send(32'h3F800000, 32'h33C00000, 1'b0, 1'b1, 32'h3F800000, 3'b001);
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b0, 32'h7F800000, 3'b011);
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b1, 32'h7F7FFFFF, 3'b011);
        send(32'h7F800000, 32'hFF800000, 1'b0, 1'b0, 32'h7FC00000, 3'b100);
        send(32'h7F800000, 32'h7F800000, 1'b1, 1'b0, 32'h7FC00000, 3'b100);
        send(32'h7FC00001, 32'h3F800000, 1'b0, 1'b0, 32'h7FC00000, 3'b000);
        send(32'h7F800000, 32'h3F800000, 1'b0, 1'b0, 32'h7F800000, 3'b000);
        send(32'h3F800000, 32'h00000000, 1'b0, 1'b0, 32'h3F800000, 3'b000);
        send(32'h00000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 3'b000);
        send(32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h80000000, 3'b000);
        send(32'h00000001, 32'h3F800000, 1'b0, 1'b0, 32'h3F800000, 3'b000);
        send(32'h3F800000, 32'h40400000, 1'b1, 1'b0, 32'hC0000000, 3'b000);
        send(32'h00800000, 32'h00800001, 1'b1, 1'b0, 32'h80000000, 3'b001);
        drain();

        // Backpressure: six back-to-back ops with a 5-cycle consumer stall.
        fork
            begin
                send(32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 32'h40000000, 3'b000);
                send(32'h40000000, 32'h40000000, 1'b0, 1'b0, 32'h40800000, 3'b000);
                send(32'h3F800000, 32'h40000000, 1'b0, 1'b0, 32'h40400000, 3'b000);
                send(32'h40800000, 32'h40800000, 1'b0, 1'b0, 32'h41000000, 3'b000);
                send(32'h41000000, 32'h3F800000, 1'b1, 1'b0, 32'h40E00000, 3'b000);
                send(32'h40800000, 32'h3F800000, 1'b0, 1'b0, 32'h40A00000, 3'b000);
            end
            begin
                repeat (4) @(posedge clk);
                #2 io.out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #2 io.out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two ops in flight and one result blocked at the output.
        @(negedge clk);
        io.out_ready = 1'b0;
        send(32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 32'h40000000, 3'b000);
        send(32'h40000000, 32'h40000000, 1'b0, 1'b0, 32'h40800000, 3'b000);
        repeat (2) @(posedge clk);
        #2;
        check("pre_rst_out_valid", 32'(io.out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(io.out_valid), 32'd0);
        check("async_rst_res", io.res, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #3;
        io.out_ready = 1'b1;
        rst = 1'b0;
        latency_test("latency_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
